// File: rtl/sl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sl_pkg
// Description : Shared definitions for the SL line receiver: FSM state
//               encoding, rx_err bit positions and the per-word status
//               record carried through the receive FIFO alongside the data.
// Revision    : 1.0 - initial release
// ============================================================================
package sl_pkg;

    // Receiver FSM states (explicit 3-bit encoding)
    typedef logic [2:0] sl_state_t;
    localparam sl_state_t c_ST_IDLE = 3'd0;
    localparam sl_state_t c_ST_LOW0 = 3'd1;
    localparam sl_state_t c_ST_LOW1 = 3'd2;
    localparam sl_state_t c_ST_WAIT = 3'd3;
    localparam sl_state_t c_ST_STOP = 3'd4;
    localparam sl_state_t c_ST_PUSH = 3'd5;

    // Bit positions inside rx_err
    localparam int c_ERR_LEN   = 3;
    localparam int c_ERR_PAR   = 2;
    localparam int c_ERR_FREQ  = 1;
    localparam int c_ERR_FRAME = 0;

    localparam int c_ERR_W = 4;
    localparam int c_LEN_W = 6;

    // Status half of a FIFO entry. The data field width follows the
    // MAX_BITS parameter of the receiver, so the full entry is
    // {sl_status_t, data[MAX_BITS-1:0]}, assembled in the receiver.
    typedef struct packed {
        logic [c_ERR_W-1:0] err;
        logic [c_LEN_W-1:0] len;
    } sl_status_t;

endpackage
`default_nettype wire

// File: rtl/sl_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sl_rx_fifo
// Description : Synchronous FIFO with a registered head entry. A push into
//               an empty FIFO lands straight in the head register, so the
//               entry is visible the cycle after the push. A push while full
//               is accepted only if the head is popped in the same cycle;
//               otherwise it is dropped and o_drop pulses.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_push, i_data      - write side
//               o_drop              - push refused because FIFO was full
//               o_valid, i_ready    - head handshake (pop = valid & ready)
//               o_data              - head entry, stable until popped
// Revision    : 1.0 - initial release
// ============================================================================
module sl_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4      // power of two, 2 or more
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_drop,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    // Entries behind the head. The head register holds one entry, so the
    // backing store never holds more than DEPTH-1.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_CW-1:0]  r_mem_cnt;
    logic [WIDTH-1:0] r_head;
    logic             r_head_vld;

    logic w_pop;
    logic w_full;
    logic w_accept;
    logic w_head_free;
    logic w_mem_rd;
    logic w_bypass;
    logic w_mem_wr;

    assign w_pop       = r_head_vld & i_ready;
    assign w_full      = r_head_vld & (r_mem_cnt == c_CW'(DEPTH - 1));
    assign w_accept    = i_push & (~w_full | w_pop);
    assign w_head_free = ~r_head_vld | w_pop;
    assign w_mem_rd    = w_head_free & (r_mem_cnt != '0);
    assign w_bypass    = w_head_free & (r_mem_cnt == '0) & w_accept;
    assign w_mem_wr    = w_accept & ~w_bypass;

    assign o_drop  = i_push & ~w_accept;
    assign o_valid = r_head_vld;
    assign o_data  = r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_head_vld <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_mem_cnt  <= '0;
        end else begin
            if (w_mem_rd) begin
                r_head   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (w_bypass) begin
                r_head <= i_data;
            end
            if (w_head_free) begin
                r_head_vld <= w_mem_rd | w_bypass;
            end
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_mem_cnt <= r_mem_cnt + c_CW'(w_mem_wr) - c_CW'(w_mem_rd);
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sl_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : sl_rx_core
// Description : Two-wire SL serial line receiver. Each wire is synchronised
//               and glitch filtered; low pulses on sl0/sl1 carry data 0/1,
//               a joint low is a stop. Words are assembled LSB first, checked
//               for length, odd parity, pulse timing and framing, and queued
//               with their status in a small FIFO drained by ready/valid.
// Ports       : clk, reset                - clock, sync active-high reset
//               sl0, sl1                  - asynchronous line, active low
//               cfg_word_len, cfg_parity_en - word checks, sampled at push
//               rx_valid/rx_ready         - FIFO head handshake
//               rx_data, rx_len, rx_err   - head entry contents
//               ovf, ovf_clr              - sticky drop flag and its clear
// Options     : SL_RX_TIMEOUT_EN - abort a word that sees no line edge for
//               TIMEOUT cycles; it is queued with the frame error set.
// Revision    : 1.0 - initial release
// ============================================================================
module sl_rx_core
    import sl_pkg::*;
#(
    parameter int MAX_BITS   = 32,   // at most 61 so counters fit 6 bits
    parameter int MIN_BITS   = 8,
    parameter int FILT_LEN   = 3,
    parameter int PULSE_MIN  = 12,
    parameter int PULSE_MAX  = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sl0,
    input  logic                sl1,
    input  logic [5:0]          cfg_word_len,
    input  logic                cfg_parity_en,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [MAX_BITS-1:0] rx_data,
    output logic [5:0]          rx_len,
    output logic [3:0]          rx_err,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int         c_FCNT_W   = $clog2(FILT_LEN + 1);
    localparam int         c_PCNT_W   = $clog2(PULSE_MAX + 2);
    localparam int         c_ENTRY_W  = c_ERR_W + c_LEN_W + MAX_BITS;
    localparam logic [c_PCNT_W-1:0] c_PCNT_SAT = c_PCNT_W'(PULSE_MAX + 1);
    localparam logic [5:0] c_BCNT_SAT = 6'(MAX_BITS + 2);
    localparam logic [5:0] c_LEN_SAT  = 6'(MAX_BITS + 1);

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchroniser + FILT_LEN sample filter.
    // Index 0 is sl0, index 1 is sl1; 1 means the wire is high.
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {sl1, sl0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
        logic                r_meta;
        logic                r_sync;
        logic                r_filt;
        logic [c_FCNT_W-1:0] r_fcnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_meta <= 1'b1;
                r_sync <= 1'b1;
                r_filt <= 1'b1;
                r_fcnt <= '0;
            end else begin
                r_meta <= w_raw[gi];
                r_sync <= r_meta;
                // Flip only after FILT_LEN consecutive differing samples
                if (r_sync != r_filt) begin
                    if (r_fcnt == c_FCNT_W'(FILT_LEN - 1)) begin
                        r_filt <= r_sync;
                        r_fcnt <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end else begin
                    r_fcnt <= '0;
                end
            end
        end

        assign w_filt[gi] = r_filt;
    end

    logic w_f0;
    logic w_f1;
    assign w_f0 = w_filt[0];
    assign w_f1 = w_filt[1];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    sl_state_t r_state;
    sl_state_t w_edge_nxt;      // next state from line activity alone
    sl_state_t w_state_nxt;
    logic      w_timeout;
    logic      w_in_word;

    logic [5:0]          r_bit_cnt;
    logic [MAX_BITS-1:0] r_shreg;
    logic                r_ones;       // running XOR of every bit received
    logic                r_err_freq;
    logic                r_err_frame;
    logic [c_PCNT_W-1:0] r_pcnt;

    assign w_in_word = (r_state == c_ST_LOW0) || (r_state == c_ST_LOW1) ||
                       (r_state == c_ST_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_edge_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_WAIT: begin
                if (!w_f0 && !w_f1) begin
                    w_edge_nxt = c_ST_STOP;
                end else if (!w_f0) begin
                    w_edge_nxt = c_ST_LOW0;
                end else if (!w_f1) begin
                    w_edge_nxt = c_ST_LOW1;
                end
            end
            c_ST_LOW0: begin
                if (w_f0) begin
                    w_edge_nxt = c_ST_WAIT;
                end else if (!w_f1) begin
                    w_edge_nxt = c_ST_STOP;
                end
            end
            c_ST_LOW1: begin
                if (w_f1) begin
                    w_edge_nxt = c_ST_WAIT;
                end else if (!w_f0) begin
                    w_edge_nxt = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                // A stop that closes no bits is not a word
                if (w_f0 && w_f1) begin
                    w_edge_nxt = (r_bit_cnt == '0) ? c_ST_IDLE : c_ST_PUSH;
                end
            end
            default: begin
                w_edge_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_state_nxt = w_timeout ? c_ST_PUSH : w_edge_nxt;

`ifdef SL_RX_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    // Every filtered edge inside a word changes state, so "no state change"
    // is the same as "no edge".
    always_ff @(posedge clk) begin
        if (reset || !w_in_word || (w_edge_nxt != r_state)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = w_in_word && (w_edge_nxt == r_state) &&
                       (r_to_cnt == c_TO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pulse length counter: restarts at 1 on entry to a low state, so at
    // the rise it holds the filtered low length (saturating).
    // ------------------------------------------------------------------
    logic w_enter_low;
    logic w_in_low;

    assign w_enter_low = (w_state_nxt != r_state) &&
                         ((w_state_nxt == c_ST_LOW0) || (w_state_nxt == c_ST_LOW1) ||
                          (w_state_nxt == c_ST_STOP));
    assign w_in_low    = (r_state == c_ST_LOW0) || (r_state == c_ST_LOW1) ||
                         (r_state == c_ST_STOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (w_enter_low) begin
            r_pcnt <= c_PCNT_W'(1);
        end else if (w_in_low && (r_pcnt != c_PCNT_SAT)) begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic                w_rise;
    logic                w_bit;
    logic                w_frame;
    logic                w_stop_end;
    logic                w_pulse_bad;
    logic [MAX_BITS-1:0] w_bit_mask;

    assign w_rise      = ((r_state == c_ST_LOW0) && w_f0) ||
                         ((r_state == c_ST_LOW1) && w_f1);
    assign w_bit       = (r_state == c_ST_LOW1);
    assign w_frame     = ((r_state == c_ST_LOW0) || (r_state == c_ST_LOW1)) &&
                         (w_edge_nxt == c_ST_STOP);
    assign w_stop_end  = (r_state == c_ST_STOP) && w_f0 && w_f1;
    assign w_pulse_bad = (r_pcnt < c_PCNT_W'(PULSE_MIN)) ||
                         (r_pcnt > c_PCNT_W'(PULSE_MAX));
    // Shifting past MAX_BITS yields zero, so extra bits are not stored
    assign w_bit_mask  = {{(MAX_BITS-1){1'b0}}, 1'b1} << r_bit_cnt;

    // Word state is cleared while idle and held through PUSH
    always_ff @(posedge clk) begin
        if (reset || (r_state == c_ST_IDLE)) begin
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_ones      <= 1'b0;
            r_err_freq  <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            if (w_rise) begin
                r_ones  <= r_ones ^ w_bit;
                r_shreg <= r_shreg | ({MAX_BITS{w_bit}} & w_bit_mask);
                if (r_bit_cnt != c_BCNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end
                if (w_pulse_bad) begin
                    r_err_freq <= 1'b1;
                end
            end
            if (w_stop_end && w_pulse_bad) begin
                r_err_freq <= 1'b1;
            end
            if (w_frame || w_timeout) begin
                r_err_frame <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry build (only meaningful in PUSH, where cfg_* are sampled)
    // ------------------------------------------------------------------
    sl_status_t          w_status;
    logic [5:0]          w_data_bits;
    logic [MAX_BITS-1:0] w_keep;

    always_comb begin
        w_status    = '0;
        w_data_bits = r_bit_cnt;
        if (cfg_parity_en && (r_bit_cnt != '0)) begin
            w_data_bits = r_bit_cnt - 6'd1;
        end
        w_status.len = (w_data_bits > c_LEN_SAT) ? c_LEN_SAT : w_data_bits;
        w_status.err[c_ERR_LEN] = (w_data_bits < 6'(MIN_BITS)) ||
                                  (w_data_bits > 6'(MAX_BITS)) ||
                                  ((cfg_word_len != '0) && (w_data_bits != cfg_word_len));
        // Odd parity: data plus parity bit must hold an odd number of ones
        w_status.err[c_ERR_PAR]   = cfg_parity_en && !r_ones;
        w_status.err[c_ERR_FREQ]  = r_err_freq;
        w_status.err[c_ERR_FRAME] = r_err_frame;
        // Clears the stored parity bit; all ones once data fills the word
        w_keep = ~({MAX_BITS{1'b1}} << w_data_bits);
    end

    // ------------------------------------------------------------------
    // FIFO and overflow flag
    // ------------------------------------------------------------------
    logic                 w_push;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_push = (r_state == c_ST_PUSH);

    sl_rx_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  ({w_status, r_shreg & w_keep}),
        .o_drop  (w_drop),
        .o_valid (rx_valid),
        .i_ready (rx_ready),
        .o_data  (w_head)
    );

    assign {rx_err, rx_len, rx_data} = w_head;

    logic r_ovf;

    // A new drop wins over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sl_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sl_rx_core
// Description : Self-checking bench for sl_rx_core. A table of words with
//               their expected entries, plus sequences for the empty stop,
//               FIFO overflow, mid-word reset and (optionally) the timeout.
// Options     : SL_RX_TIMEOUT_EN - also exercises the word timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sl_rx_core;

    localparam int MAX_BITS = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                sl0;
    logic                sl1;
    logic [5:0]          cfg_word_len;
    logic                cfg_parity_en;
    logic                rx_valid;
    logic                rx_ready;
    logic [MAX_BITS-1:0] rx_data;
    logic [5:0]          rx_len;
    logic [3:0]          rx_err;
    logic                ovf;
    logic                ovf_clr;

    always #5 clk = ~clk;

    sl_rx_core dut (
        .clk           (clk),
        .reset         (reset),
        .sl0           (sl0),
        .sl1           (sl1),
        .cfg_word_len  (cfg_word_len),
        .cfg_parity_en (cfg_parity_en),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_len        (rx_len),
        .rx_err        (rx_err),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] bits;      // line bits, LSB sent first (incl. parity)
        int          nbits;
        int          plen;      // low pulse length of every data bit
        bit          glitch;    // 1-cycle sl0 glitch in the gap after bit 2
        logic [5:0]  wlen;
        bit          par;
        logic [31:0] exp_data;
        logic [5:0]  exp_len;
        logic [3:0]  exp_err;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int plen, input bit glitch);
        if (b) sl1 = 1'b0;
        else   sl0 = 1'b0;
        tick(plen);
        sl0 = 1'b1;
        sl1 = 1'b1;
        if (glitch) begin
            tick(5);
            sl0 = 1'b0;
            tick(1);
            sl0 = 1'b1;
            tick(10);
        end else begin
            tick(16);
        end
    endtask

    task automatic send_stop(input int slen);
        sl0 = 1'b0;
        sl1 = 1'b0;
        tick(slen);
        sl0 = 1'b1;
        sl1 = 1'b1;
        tick(16);
    endtask

    task automatic send_bits(input logic [63:0] bits, input int nbits, input int plen,
                             input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i], plen, glitch && (i == 2));
        end
    endtask

    task automatic send_word(input logic [63:0] bits, input int nbits, input int plen,
                             input bit glitch);
        send_bits(bits, nbits, plen, glitch);
        send_stop(16);
    endtask

    task automatic expect_entry(input string name, input logic [31:0] d,
                                input logic [5:0] l, input logic [3:0] e);
        int n = 0;
        while (!rx_valid && n < 200) begin
            tick(1);
            n++;
        end
        check({name, "_valid"}, 64'(rx_valid), 64'd1);
        if (rx_valid) begin
            check({name, "_data"}, 64'(rx_data), 64'(d));
            check({name, "_len"},  64'(rx_len),  64'(l));
            check({name, "_err"},  64'(rx_err),  64'(e));
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        // bits, nbits, plen, glitch, wlen, par, exp_data, exp_len, exp_err, name
        // 0xA5C3 has 8 ones -> odd parity bit is 1
        vecs[0] = '{64'h1_A5C3,     17, 16, 1'b0, 6'd16, 1'b1, 32'h0000A5C3, 6'd16, 4'b0000, "par_ok"};
        vecs[1] = '{64'h0_A5C3,     17, 16, 1'b0, 6'd16, 1'b1, 32'h0000A5C3, 6'd16, 4'b0100, "par_bad"};
        vecs[2] = '{64'h5A,          8, 16, 1'b1, 6'd0,  1'b0, 32'h0000005A, 6'd8,  4'b0000, "glitch"};
        vecs[3] = '{64'h5A,          8,  5, 1'b0, 6'd0,  1'b0, 32'h0000005A, 6'd8,  4'b0010, "short"};
        vecs[4] = '{64'h5A,          8, 24, 1'b0, 6'd0,  1'b0, 32'h0000005A, 6'd8,  4'b0010, "long"};
        vecs[5] = '{64'hABC,        12, 16, 1'b0, 6'd16, 1'b0, 32'h00000ABC, 6'd12, 4'b1000, "len12"};
        vecs[6] = '{64'h1_DEADBEEF, 33, 16, 1'b0, 6'd0,  1'b0, 32'hDEADBEEF, 6'd33, 4'b1000, "len33"};
        // 0x3C has 4 ones -> parity bit 1
        vecs[7] = '{64'h13C,         9, 16, 1'b0, 6'd0,  1'b1, 32'h0000003C, 6'd8,  4'b0000, "par8"};
        vecs[8] = '{64'h55,          7, 16, 1'b0, 6'd8,  1'b0, 32'h00000055, 6'd7,  4'b1000, "min7"};
        vecs[9] = '{64'h12345678,   32, 16, 1'b0, 6'd32, 1'b0, 32'h12345678, 6'd32, 4'b0000, "max32"};

        sl0           = 1'b1;
        sl1           = 1'b1;
        reset         = 1'b1;
        rx_ready      = 1'b0;
        ovf_clr       = 1'b0;
        cfg_word_len  = 6'd0;
        cfg_parity_en = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(2);

        // Reset state
        check("rst_valid", 64'(rx_valid), 64'd0);
        check("rst_data",  64'(rx_data),  64'd0);
        check("rst_len",   64'(rx_len),   64'd0);
        check("rst_err",   64'(rx_err),   64'd0);
        check("rst_ovf",   64'(ovf),      64'd0);

        // Table-driven words
        for (int v = 0; v < 10; v++) begin
            cfg_word_len  = vecs[v].wlen;
            cfg_parity_en = vecs[v].par;
            send_word(vecs[v].bits, vecs[v].nbits, vecs[v].plen, vecs[v].glitch);
            expect_entry(vecs[v].name, vecs[v].exp_data, vecs[v].exp_len, vecs[v].exp_err);
        end

        // A stop with no bits queues nothing
        cfg_word_len  = 6'd0;
        cfg_parity_en = 1'b0;
        send_stop(16);
        tick(20);
        check("empty_stop_valid", 64'(rx_valid), 64'd0);

        // Overflow: 4 entries fit, the 5th is dropped, head stays put
        for (int w = 1; w <= 4; w++) begin
            send_word(64'(w), 8, 16, 1'b0);
        end
        check("ovf_before", 64'(ovf), 64'd0);
        send_word(64'd5, 8, 16, 1'b0);
        check("ovf_set",       64'(ovf),      64'd1);
        check("ovf_head_vld",  64'(rx_valid), 64'd1);
        check("ovf_head_data", 64'(rx_data),  64'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 64'(ovf), 64'd0);
        for (int w = 1; w <= 4; w++) begin
            expect_entry($sformatf("drain%0d", w), 32'(w), 6'd8, 4'b0000);
        end
        tick(2);
        check("drain_empty", 64'(rx_valid), 64'd0);

        // Reset mid-word discards the partial word
        send_bits(64'h7F, 7, 16, 1'b0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("midrst_valid", 64'(rx_valid), 64'd0);
        send_word(64'h3C, 8, 16, 1'b0);
        expect_entry("after_rst", 32'h3C, 6'd8, 4'b0000);
        tick(40);
        check("after_rst_single", 64'(rx_valid), 64'd0);

`ifdef SL_RX_TIMEOUT_EN
        // Word left open after 10 bits is flushed by the timeout
        begin
            int n = 0;
            send_bits(64'h2AA, 10, 16, 1'b0);
            while (!rx_valid && n < 600) begin
                tick(1);
                n++;
            end
            check("to_delay", 64'((n >= 200) && (n <= 300)), 64'd1);
            expect_entry("timeout", 32'h2AA, 6'd10, 4'b0001);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
